// File: rtl/vga_frame_monitor_if.sv
// Avalon-MM slave bus used to read back VGA monitor results and program the probe.
interface vga_frame_monitor_if;
  logic       chipselect;
  logic       read;
  logic       write;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (output chipselect, read, write, address, writedata, input readdata);
  modport slave  (input chipselect, read, write, address, writedata, output readdata);
endinterface

// File: rtl/vga_frame_monitor.sv
// Passive VGA bus receiver: recovers pixel/line position, checks frame geometry,
// captures the colour at a probe coordinate and reports through an Avalon slave.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      VGA_CLK,
  input  logic                      VGA_HS,
  input  logic                      VGA_VS,
  input  logic                      VGA_BLANK_n,
  input  logic [7:0]                VGA_R,
  input  logic [7:0]                VGA_G,
  input  logic [7:0]                VGA_B,
  vga_frame_monitor_if.slave        bus
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2, ERROR = 2'd3} state_t;

  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [8:0] V_ACT = 9'(V_ACTIVE);
  localparam logic [9:0] V_TOT = 10'(V_TOTAL);

  logic       vclk_p1, hs_p1, vs_p1, blank_p1;
  logic [7:0] r_p1, g_p1, b_p1;
  logic       vclk_p2, hs_p2, vs_p2;

  state_t     state;
  logic [9:0] x, total_lines, last_width, probe_x;
  logic [8:0] active_lines, last_height, probe_y;
  logic       frame_bad, cap_valid, err_sticky;
  logic [7:0] frame_count, error_count, cap_r, cap_g, cap_b, rd_data;

  // Stage 1 samples the VGA bus, stage 2 holds the previous sample for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vclk_p1 <= 1'b0; hs_p1 <= 1'b0; vs_p1 <= 1'b0; blank_p1 <= 1'b0;
      r_p1 <= '0; g_p1 <= '0; b_p1 <= '0;
      vclk_p2 <= 1'b0; hs_p2 <= 1'b0; vs_p2 <= 1'b0;
    end else begin
      vclk_p1 <= VGA_CLK; hs_p1 <= VGA_HS; vs_p1 <= VGA_VS; blank_p1 <= VGA_BLANK_n;
      r_p1 <= VGA_R; g_p1 <= VGA_G; b_p1 <= VGA_B;
      vclk_p2 <= vclk_p1; hs_p2 <= hs_p1; vs_p2 <= vs_p1;
    end
  end

  logic pix_stb, hs_fall, vs_fall, active_pix, wr_en, rd_en;
  assign pix_stb    = vclk_p1 & ~vclk_p2;
  assign hs_fall    = hs_p2 & ~hs_p1;
  assign vs_fall    = vs_p2 & ~vs_p1;
  assign active_pix = pix_stb & blank_p1;
  assign wr_en      = bus.chipselect & bus.write;
  assign rd_en      = bus.chipselect & bus.read;

  // Line accounting resolved first so a coincident vs_fall judges the updated counts
  logic [9:0] tl_line;
  logic [8:0] al_line;
  logic       fb_line, frame_good;
  always_comb begin
    tl_line = total_lines;
    al_line = active_lines;
    fb_line = frame_bad;
    if (hs_fall) begin
      if (total_lines != 10'h3FF) tl_line = total_lines + 10'd1;
      if (x != '0) begin
        if (active_lines != 9'h1FF) al_line = active_lines + 9'd1;
        if (x != H_ACT) fb_line = 1'b1;
      end
    end
  end
  assign frame_good = !fb_line && (al_line == V_ACT) && (tl_line == V_TOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEARCH;
      x <= '0; total_lines <= '0; active_lines <= '0; frame_bad <= 1'b0;
      last_width <= '0; last_height <= '0;
      frame_count <= '0; error_count <= '0; err_sticky <= 1'b0;
      probe_x <= '0; probe_y <= '0;
      cap_r <= '0; cap_g <= '0; cap_b <= '0; cap_valid <= 1'b0;
    end else begin
      if (hs_fall)                       x <= '0;
      else if (active_pix && x != 10'h3FF) x <= x + 10'd1;

      if (hs_fall && x != '0) last_width <= x;

      if (vs_fall) begin
        total_lines  <= '0;
        active_lines <= '0;
        frame_bad    <= 1'b0;
        if (state == SEARCH) begin
          state <= MEASURE;
        end else begin
          last_height <= al_line;
          if (frame_good) begin
            state       <= LOCKED;
            frame_count <= frame_count + 8'd1;
          end else begin
            state      <= ERROR;
            err_sticky <= 1'b1;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          end
        end
      end else begin
        total_lines  <= tl_line;
        active_lines <= al_line;
        frame_bad    <= fb_line;
      end

      if (active_pix && x == probe_x && active_lines == probe_y) begin
        cap_r <= r_p1; cap_g <= g_p1; cap_b <= b_p1;
        cap_valid <= 1'b1;
      end

      // A new probe position invalidates the old capture, even in the capture cycle
      if (wr_en) begin
        case (bus.address)
          3'd0: begin probe_x[7:0] <= bus.writedata;      cap_valid <= 1'b0; end
          3'd1: begin probe_x[9:8] <= bus.writedata[1:0]; cap_valid <= 1'b0; end
          3'd2: begin probe_y[7:0] <= bus.writedata;      cap_valid <= 1'b0; end
          3'd3: begin probe_y[8]   <= bus.writedata[0];   cap_valid <= 1'b0; end
          3'd7: if (bus.writedata[0]) begin error_count <= '0; err_sticky <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      case (bus.address)
        3'd0: rd_data <= cap_r;
        3'd1: rd_data <= cap_g;
        3'd2: rd_data <= cap_b;
        3'd3: rd_data <= {3'b000, err_sticky, cap_valid, 1'b0, 2'(state)};
        3'd4: rd_data <= frame_count;
        3'd5: rd_data <= error_count;
        3'd6: rd_data <= last_width[9:2];
        default: rd_data <= last_height[8:1];
      endcase
    end
  end

  assign bus.readdata = rd_data;

  logic unused_bits;
  assign unused_bits = ^{last_width[1:0], last_height[0]};

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench: drives a reduced-size VGA raster and checks monitor registers.
module tb_vga_frame_monitor;
  localparam int HA = 40;
  localparam int VA = 24;
  localparam int VT = 30;
  localparam int HOT_X = 10;
  localparam int HOT_Y = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vga_clk = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1, vga_blank = 1'b0;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic [7:0] rd_val;

  int n_cmp = 0;
  int n_bad = 0;

  vga_frame_monitor_if av();

  vga_frame_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .VGA_CLK    (vga_clk),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .VGA_BLANK_n(vga_blank),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b),
    .bus        (av)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One pixel: VGA_CLK low for one clk, high for the next
  task automatic pix(input bit blank, input bit hs, input bit vs, input logic [23:0] rgb);
    @(posedge clk); #1;
    vga_clk = 1'b0; vga_blank = blank; vga_hs = hs; vga_vs = vs;
    {vga_r, vga_g, vga_b} = rgb;
    @(posedge clk); #1;
    vga_clk = 1'b1;
  endtask

  task automatic gen_line(input int row, input int width, input bit vs_pulse);
    for (int p = 0; p < width; p++)
      pix(1'b1, 1'b1, 1'b1, (row == HOT_Y && p == HOT_X) ? 24'h123456 : 24'h000080);
    for (int p = 0; p < 8; p++)
      pix(1'b0, !(p == 2 || p == 3), !(vs_pulse && (p == 5 || p == 6)), 24'h000000);
  endtask

  task automatic frame_seg(input int from_row, input int to_row, input int n_total,
                           input int bad_row, input int bad_w, input bit with_vs);
    for (int r = from_row; r < to_row; r++)
      gen_line(r, (r < VA) ? ((r == bad_row) ? bad_w : HA) : 0, with_vs && (r == n_total - 1));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic gen_frame(input int n_total, input int bad_row, input int bad_w);
    frame_seg(0, n_total, n_total, bad_row, bad_w, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    av.chipselect = 1'b1; av.read = 1'b1; av.address = a;
    @(posedge clk); #1;
    av.chipselect = 1'b0; av.read = 1'b0;
    d = av.readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    av.chipselect = 1'b1; av.write = 1'b1; av.address = a; av.writedata = d;
    @(posedge clk); #1;
    av.chipselect = 1'b0; av.write = 1'b0;
  endtask

  task automatic exp_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
    logic [7:0] d;
    rd(a, d);
    chk(tag, d, e);
  endtask

  initial begin
    av.chipselect = 1'b0; av.read = 1'b0; av.write = 1'b0;
    av.address = '0; av.writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", av.readdata, 8'h00);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rd_val);
      chk($sformatf("reset_reg%0d", a), rd_val, 8'h00);
    end

    // Frame 1 only arms the checker; probe (0,0) captures the background colour
    gen_frame(VT, -1, 0);
    exp_reg("f1_status", 3'd3, 8'h09);
    gen_frame(VT, -1, 0);
    exp_reg("f2_status", 3'd3, 8'h0A);
    exp_reg("f2_frames", 3'd4, 8'h01);
    gen_frame(VT, -1, 0);
    exp_reg("f3_frames", 3'd4, 8'h02);
    exp_reg("f3_width",  3'd6, 8'h0A);
    exp_reg("f3_height", 3'd7, 8'h0C);
    exp_reg("f3_cap_r",  3'd0, 8'h00);
    exp_reg("f3_cap_b",  3'd2, 8'h80);

    wr(3'd0, 8'(HOT_X)); wr(3'd1, 8'h00); wr(3'd2, 8'(HOT_Y)); wr(3'd3, 8'h00);
    exp_reg("probe_clr_status", 3'd3, 8'h02);
    gen_frame(VT, -1, 0);
    exp_reg("probe_r", 3'd0, 8'h12);
    exp_reg("probe_g", 3'd1, 8'h34);
    exp_reg("probe_b", 3'd2, 8'h56);
    exp_reg("probe_status", 3'd3, 8'h0A);
    exp_reg("f4_frames", 3'd4, 8'h03);

    // Row 10 one pixel short
    gen_frame(VT, 10, HA - 1);
    exp_reg("short_status", 3'd3, 8'h1B);
    exp_reg("short_errors", 3'd5, 8'h01);
    exp_reg("short_width",  3'd6, 8'h0A);
    gen_frame(VT, -1, 0);
    exp_reg("recover_status", 3'd3, 8'h1A);
    exp_reg("recover_frames", 3'd4, 8'h04);

    wr(3'd7, 8'h01);
    exp_reg("errclr_errors", 3'd5, 8'h00);
    exp_reg("errclr_status", 3'd3, 8'h0A);

    gen_frame(VT - 1, -1, 0);
    exp_reg("short_tot_status", 3'd3, 8'h1B);
    exp_reg("short_tot_errors", 3'd5, 8'h01);
    exp_reg("short_tot_frames", 3'd4, 8'h04);

    // Last active row far beyond 1023 pixels: x must saturate
    gen_frame(VT, VA - 1, 1030);
    exp_reg("long_width",  3'd6, 8'hFF);
    exp_reg("long_errors", 3'd5, 8'h02);
    exp_reg("long_height", 3'd7, 8'h0C);

    // Reset mid-frame at row 12
    frame_seg(0, 12, VT, -1, 0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_readdata", av.readdata, 8'h00);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rd_val);
      chk($sformatf("midreset_reg%0d", a), rd_val, 8'h00);
    end
    frame_seg(12, VT, VT, -1, 0, 1'b1);
    exp_reg("post_reset_vs1", 3'd3, 8'h09);
    gen_frame(VT, -1, 0);
    exp_reg("post_reset_vs2", 3'd3, 8'h0A);
    exp_reg("post_reset_frames", 3'd4, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
